// File: rtl/dec_accum.sv
// ----------------------------------------------------------------------------
// dec_accum
//
// Collects a stream of decimal digit nibbles (0-9) into an unsigned binary
// number. Any nibble 10-15 terminates the number. The finished number is then
// offered on a valid/ready output port. Numbers that do not fit in W bits, or
// that have more than MAXD digits, saturate to all ones and raise ovf.
//
// Parameters:
//   W        result width in bits (4..32)
//   MAXD     maximum digits per number (1..15)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   nib      digit (0-9) or terminator (10-15)
//   nib_vld  nib is valid
//   nib_rdy  block accepts nib this cycle (low only while a result waits)
//   val      accumulated result
//   val_vld  val/ndig/ovf are valid
//   val_rdy  consumer takes the result
//   ndig     digits received, saturating at MAXD
//   ovf      result saturated (value overflow or too many digits)
// ----------------------------------------------------------------------------
module dec_accum #(
    parameter int W    = 16,
    parameter int MAXD = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   nib,
    input  logic         nib_vld,
    output logic         nib_rdy,
    output logic [W-1:0] val,
    output logic         val_vld,
    input  logic         val_rdy,
    output logic [3:0]   ndig,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] MaxDig = 4'(MAXD);

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           ovf_q, ovf_d;

    logic           inXfer;
    logic           isDigit;
    logic [W+3:0]   nextVal;
    logic           valTooBig;
    logic [3:0]     cntInc;

    // acc*10 + d computed four bits wider than acc so that any value
    // overflow shows up in the top nibble instead of wrapping.
    always_comb begin
        nextVal   = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                  + {{W{1'b0}}, nib};
        valTooBig = (nextVal[W+3:W] != 4'd0);
        cntInc    = (cnt_q < MaxDig) ? (cnt_q + 4'd1) : cnt_q;
    end

    // Handshake decode comes only from the registered state, so there is no
    // combinational path from val_rdy to nib_rdy.
    assign nib_rdy = (state_q != DONE);
    assign val_vld = (state_q == DONE);
    assign inXfer  = nib_vld && nib_rdy;
    assign isDigit = (nib < 4'd10);

    // Outputs always reflect the registered accumulator; they only carry
    // meaning while val_vld is high.
    assign val  = acc_q;
    assign ndig = cnt_q;
    assign ovf  = ovf_q;

    // Next-state and accumulator update. Once ovf is set, later digits keep
    // acc pinned at all ones until the result has been handed off.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (inXfer && isDigit) begin
                    acc_d   = {{(W-4){1'b0}}, nib};
                    cnt_d   = 4'd1;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (inXfer) begin
                    if (isDigit) begin
                        if ((cnt_q == MaxDig) || valTooBig || ovf_q) begin
                            acc_d = {W{1'b1}};
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = nextVal[W-1:0];
                        end
                        cnt_d = cntInc;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (val_rdy) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = 4'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any number in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dec_accum.sv
// ----------------------------------------------------------------------------
// tb_dec_accum
//
// Directed bench for dec_accum (W=16, MAXD=5). Expected results are queued
// when the terminating nibble is driven and compared when the DUT hands a
// result over on the output port.
// ----------------------------------------------------------------------------
module tb_dec_accum;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  n;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  nib;
    logic        nib_vld;
    logic        nib_rdy;
    logic [15:0] val;
    logic        val_vld;
    logic        val_rdy;
    logic [3:0]  ndig;
    logic        ovf;

    int   checkCount = 0;
    int   passCount  = 0;
    exp_t sb[$];

    dec_accum #(.W(16), .MAXD(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .nib     (nib),
        .nib_vld (nib_vld),
        .nib_rdy (nib_rdy),
        .val     (val),
        .val_vld (val_vld),
        .val_rdy (val_rdy),
        .ndig    (ndig),
        .ovf     (ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Drive one nibble and hold it until it has been accepted (bounded).
    task automatic applyStimulus(input logic [3:0] n);
        int waitCnt;
        waitCnt = 0;
        nib     = n;
        nib_vld = 1'b1;
        @(negedge clk);
        while (!nib_rdy && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 50)
            checkOutput("nibAcceptTimeout", 32'(waitCnt), 32'd0);
        @(posedge clk);
        #1;
        nib_vld = 1'b0;
    endtask

    task automatic pushExp(input logic [15:0] v, input logic [3:0] n,
                           input logic o);
        exp_t e;
        e.v = v;
        e.n = n;
        e.o = o;
        sb.push_back(e);
    endtask

    // Result monitor: a transfer happens on the next rising edge whenever
    // val_vld and val_rdy are both high mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && val_vld && val_rdy) begin
            checkCount++;
            assert (sb.size() != 0) passCount++;
            else $error("[TB] FAIL unexpectedResult observed=%0d expected=none", val);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("resultVal",  32'(val),  32'(e.v));
                checkOutput("resultNdig", 32'(ndig), 32'(e.n));
                checkOutput("resultOvf",  32'(ovf),  32'(e.o));
            end
        end
    end

    initial begin
        int waitCnt;
        rst     = 1'b1;
        nib     = 4'd0;
        nib_vld = 1'b0;
        val_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rstVal",    32'(val),     32'd0);
        checkOutput("rstValVld", 32'(val_vld), 32'd0);
        checkOutput("rstNibRdy", 32'(nib_rdy), 32'd1);
        checkOutput("rstNdig",   32'(ndig),    32'd0);
        checkOutput("rstOvf",    32'(ovf),     32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1,2,3,F -> 123; one cycle of val_vld and of nib_rdy low
        $display("[TB] basic 123");
        pushExp(16'd123, 4'd3, 1'b0);
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        applyStimulus(4'd3);
        applyStimulus(4'hF);
        checkOutput("doneValVld", 32'(val_vld), 32'd1);
        checkOutput("doneNibRdy", 32'(nib_rdy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("afterValVld", 32'(val_vld), 32'd0);
        checkOutput("afterNibRdy", 32'(nib_rdy), 32'd1);

        // Leading terminators discarded, then 65535 exactly fits
        $display("[TB] max value");
        applyStimulus(4'hF);
        applyStimulus(4'hF);
        checkOutput("leadTermNoVld", 32'(val_vld), 32'd0);
        pushExp(16'hFFFF, 4'd5, 1'b0);
        applyStimulus(4'd6);
        applyStimulus(4'd5);
        applyStimulus(4'd5);
        applyStimulus(4'd3);
        applyStimulus(4'd5);
        applyStimulus(4'hF);
        @(posedge clk);
        #1;

        // 65536 overflows the value
        $display("[TB] value overflow");
        pushExp(16'hFFFF, 4'd5, 1'b1);
        applyStimulus(4'd6);
        applyStimulus(4'd5);
        applyStimulus(4'd5);
        applyStimulus(4'd3);
        applyStimulus(4'd6);
        checkOutput("ovfSameEdge", 32'(ovf), 32'd1);
        applyStimulus(4'hF);
        @(posedge clk);
        #1;

        // Sixth digit exceeds MAXD, leading zeros counted
        $display("[TB] digit overflow");
        pushExp(16'hFFFF, 4'd5, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(4'd0);
        checkOutput("zerosNoOvf", 32'(ovf), 32'd0);
        applyStimulus(4'd1);
        applyStimulus(4'hF);
        @(posedge clk);
        #1;

        // Back-pressure: result held while val_rdy low, producer waits
        $display("[TB] backpressure");
        val_rdy = 1'b0;
        pushExp(16'd42, 4'd2, 1'b0);
        applyStimulus(4'd4);
        applyStimulus(4'd2);
        applyStimulus(4'hA);
        nib     = 4'd7;
        nib_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("holdNibRdy", 32'(nib_rdy), 32'd0);
            checkOutput("holdVal",    32'(val),     32'd42);
            checkOutput("holdValVld", 32'(val_vld), 32'd1);
        end
        @(posedge clk);
        #1;
        val_rdy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseNibRdy", 32'(nib_rdy), 32'd1);
        @(posedge clk);
        #1;
        nib_vld = 1'b0;
        checkOutput("sevenTaken", 32'(val), 32'd7);
        pushExp(16'd7, 4'd1, 1'b0);
        applyStimulus(4'hF);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-number
        $display("[TB] reset mid-number");
        applyStimulus(4'd9);
        applyStimulus(4'd8);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValVld", 32'(val_vld), 32'd0);
        checkOutput("asyncRstVal",    32'(val),     32'd0);
        checkOutput("asyncRstNdig",   32'(ndig),    32'd0);
        checkOutput("asyncRstNibRdy", 32'(nib_rdy), 32'd1);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pushExp(16'd5, 4'd1, 1'b0);
        applyStimulus(4'd5);
        applyStimulus(4'hF);
        @(posedge clk);
        #1;

        // Back-to-back numbers with nib_vld held
        $display("[TB] back-to-back");
        pushExp(16'd1, 4'd1, 1'b0);
        pushExp(16'd2, 4'd1, 1'b0);
        applyStimulus(4'd1);
        applyStimulus(4'hF);
        applyStimulus(4'd2);
        applyStimulus(4'hF);

        waitCnt = 0;
        while (sb.size() != 0 && waitCnt < 20) begin
            @(posedge clk);
            waitCnt++;
        end
        #1;
        checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dec_accum.md
# dec_accum

Downstream consumer of the ASCII-digit-to-nibble converter. Accepts a stream of nibbles, one per handshake, where 0–9 is a decimal digit and any value 10–15 is a terminator (the converter emits 4'b1111 for non-digits). Accumulates consecutive digits into an unsigned binary value and presents it on a valid/ready output port. Intended use: parsing decimal numbers typed over a serial text link.

## Interface

Parameters:
- `W`, default 16: result width in bits; valid range 4–32.
- `MAXD`, default 5: maximum digits per number; valid range 1–15.

Ports (all single-bit unless a width is given):
- `clk`, input: rising-edge clock.
- `rst`, input: reset, asynchronous and active-high.
- `nib`, input, 4 bits: digit or terminator.
- `nib_vld`, input: `nib` is valid.
- `nib_rdy`, output: block accepts `nib` this cycle.
- `val`, output, W bits: accumulated result.
- `val_vld`, output: `val`, `ndig` and `ovf` are valid.
- `val_rdy`, input: consumer takes the result.
- `ndig`, output, 4 bits: number of digits received, saturating at MAXD.
- `ovf`, output: result saturated because of value overflow or more than MAXD digits.

## Operation

- Input transfer occurs on a rising edge with `nib_vld` & `nib_rdy`. Output transfer occurs with `val_vld` & `val_rdy`.
- A nibble is a digit when it is < 10. Otherwise it is a terminator.
- `nib_rdy` = (state != DONE), registered-state decode with no combinational path from `val_rdy`.
- `val_vld` = (state == DONE).

State machine with internal `acc` (W bits), `cnt` (4 bits) and `ovf_r`:
- **IDLE**
  - Digit d accepted: `acc`=d, `cnt`=1, `ovf_r`=0, go to ACC.
  - Terminator accepted: discarded, stay in IDLE. This covers leading separators and empty fields.
- **ACC**
  - Digit d accepted:
    - Compute t = `acc`*10 + d at W+4 bits.
    - If `cnt`==MAXD, or t > 2^W−1: `acc` = all ones, `ovf_r`=1.
    - Otherwise `acc`=t[W-1:0].
    - In both cases `cnt` increments, saturating at MAXD.
  - Terminator accepted: go to DONE; `acc`, `cnt` and `ovf_r` hold.
- **DONE**
  - `val`=`acc`, `ndig`=`cnt`, `ovf`=`ovf_r`.
  - No input is accepted.
  - When `val_rdy`=1: go to IDLE, clear `acc`, `cnt` and `ovf_r`.

Overflow rules:
- Once `ovf_r` is set it stays set until the result is transferred. Later digits keep `acc` at all ones.
- Leading zeros count toward MAXD.

Output rules:
- `val`, `ndig` and `ovf` drive the registered `acc`, `cnt` and `ovf_r` in every state.
- Consumers must sample these outputs only while `val_vld`=1.

Reset:
- `rst` asserted at any time, including mid-number or in DONE, returns the block to IDLE immediately.
- The number in progress is discarded.

## Timing

- Reset values: state IDLE, `val`=0, `val_vld`=0, `nib_rdy`=1, `ndig`=0, `ovf`=0.
- Input throughput is one nibble per cycle while `nib_rdy`=1.
- A terminator accepted on edge k raises `val_vld` after edge k.
  - If `val_rdy`=1 is already held, the transfer happens on edge k+1.
  - `nib_rdy` returns high after edge k+1.
  - Minimum gap between results is therefore 1 cycle of `nib_rdy`=0.
- While `val_vld`=1 and `val_rdy`=0, the outputs `val`, `ndig` and `ovf` are held stable for any number of cycles.
- If `nib_vld`=1 while `nib_rdy`=0, the nibble is not consumed. The producer must hold it.
- Overflow timing: the digit that causes overflow is accepted on edge k, and `acc` saturates on that same edge. No extra cycle is added.
- `val_rdy` is ignored outside DONE.

## Test plan

- Nibbles 1,2,3,F with `val_rdy`=1 → `val`=123, `ndig`=3, `ovf`=0. `val_vld` is high for exactly 1 cycle, and `nib_rdy` is low for exactly 1 cycle.
- F,F,6,5,5,3,5,F (W=16) → `val`=65535, `ndig`=5, `ovf`=0. The leading Fs produce no output.
- 6,5,5,3,6,F → `val`=65535, `ovf`=1. Separately, 0,0,0,0,0,1,F (MAXD=5) → `val`=65535, `ndig`=5, `ovf`=1.
- 4,2,A then `val_rdy`=0 for 5 cycles while the producer drives 7 → `nib_rdy`=0 and `val`=42 are held for all 5 cycles. After `val_rdy`=1, the nibble 7 is accepted on the next cycle.
- 9,8 then `rst` pulse mid-cycle → `val_vld`=0 and `val`=0 immediately. Then 5,F → `val`=5, `ndig`=1.
- Back-to-back 1,F,2,F with `nib_vld` held continuously → two results, 1 then 2. No nibble is lost or duplicated.
